// File: rtl/packet_mem_tx_if.sv
// Bundle between the packet memory read port, the transmit pins and the
// packet transmitter.
//
// Handshakes (all single-cycle, no back-pressure):
//   - olen_pop is high for exactly one cycle and consumes the head entry of
//     the length FIFO. iempty/ilen_pac describe the new head from the
//     following cycle on.
//   - ord_en is a read strobe, one byte per cycle it is high. The byte
//     appears on ird_data in the cycle after the strobe.
//   - itx_allow is a level-sensitive pause control. It is only looked at
//     between frames.
//   - otx_en/otx_d form a GMII-style stream with no ready. The PHY takes a
//     byte every cycle that otx_en is high.
interface packet_mem_tx_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pLEN_WIDTH  = 11
);
  // memory / control side, driven towards the transmitter
  logic                   iempty;
  logic [pLEN_WIDTH-1:0]  ilen_pac;
  logic [pDATA_WIDTH-1:0] ird_data;
  logic                   itx_allow;

  // transmitter outputs
  logic                   ord_en;
  logic                   olen_pop;
  logic [pDATA_WIDTH-1:0] otx_d;
  logic                   otx_en;
  logic                   obusy;
  logic                   opkt_done;
  logic                   olen_err;
  logic [15:0]            opkt_cnt;

  // FSM state for observation (IDLE=0, PREAMBLE=1, SFD=2, DATA=3, IFG=4)
  logic [2:0]             state_dbg;

  modport master (
    input  iempty, ilen_pac, ird_data, itx_allow,
    output ord_en, olen_pop, otx_d, otx_en, obusy, opkt_done, olen_err,
           opkt_cnt, state_dbg
  );

  modport slave (
    output iempty, ilen_pac, ird_data, itx_allow,
    input  ord_en, olen_pop, otx_d, otx_en, obusy, opkt_done, olen_err,
           opkt_cnt, state_dbg
  );
endinterface

// File: rtl/packet_mem_tx.sv
// Packet transmitter: pulls complete packets from the packet memory and
// sends each one as preamble, SFD and payload on an 8-bit GMII-style
// interface. An inter-frame gap follows every frame. Every output is a flop.
module packet_mem_tx #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT),
  parameter int pPREAMBLE_LEN      = 7,
  parameter int pIFG_LEN           = 12
) (
  input  logic            iclk,
  input  logic            i_rst,
  packet_mem_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    IFG      = 3'd4
  } state_t;

  // one counter serves both the preamble and the gap phases
  localparam int CNT_MAX = (pPREAMBLE_LEN > pIFG_LEN) ? pPREAMBLE_LEN : pIFG_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(pPREAMBLE_LEN - 1);
  // The first read strobe must lead the SFD by one cycle and the read data
  // path by one more, so it is issued in the second-to-last preamble cycle.
  localparam logic [CNT_W-1:0] PRE_RD   = CNT_W'(pPREAMBLE_LEN - 2);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(pIFG_LEN - 1);

  localparam logic [pDATA_WIDTH-1:0] PRE_BYTE = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE = pDATA_WIDTH'(8'hD5);
  localparam logic [pLEN_WIDTH-1:0]  LEN_ONE  = pLEN_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [pLEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;  // payload bytes still to drive
  logic [pLEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;      // read strobes still to issue
  logic                   allow_q;
  logic                   ord_en_q, ord_en_d;
  logic                   len_pop_q, len_pop_d;
  logic [pDATA_WIDTH-1:0] tx_d_q, tx_d_d;
  logic                   tx_en_q, tx_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   len_err_q, len_err_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;

  logic                   len_ok;
  logic                   req;
  logic                   start;
  logic                   rd_go;
  logic [pLEN_WIDTH-1:0]  rd_avail;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    tx_d_d     = tx_d_q;
    tx_en_d    = tx_en_q;
    len_pop_d  = 1'b0;
    len_err_d  = 1'b0;
    done_d     = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    start      = 1'b0;
    rd_go      = 1'b0;
    rd_avail   = rd_cnt_q;
    ord_en_d   = 1'b0;

    len_ok = (bus.ilen_pac != '0) &&
             (int'(bus.ilen_pac) <= pMAX_PACKET_LENGHT);
    // The head entry is stale in the cycle a pop is still in flight, so no
    // decision is taken then.
    req = !bus.iempty && allow_q && !len_pop_q;

    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        tx_d_d  = '0;
        if (req) begin
          len_pop_d = 1'b1;
          if (len_ok) begin
            start      = 1'b1;
            state_d    = PREAMBLE;
            cnt_d      = '0;
            byte_cnt_d = bus.ilen_pac;
            rd_cnt_d   = bus.ilen_pac;
            tx_en_d    = 1'b1;
            tx_d_d     = PRE_BYTE;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          cnt_d   = '0;
          tx_d_d  = SFD_BYTE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          tx_d_d = PRE_BYTE;
        end
      end

      SFD: begin
        state_d = DATA;
        tx_d_d  = bus.ird_data;
      end

      DATA: begin
        if (byte_cnt_q <= LEN_ONE) begin
          // last payload byte is on the pins now; open the gap
          state_d    = IFG;
          cnt_d      = '0;
          byte_cnt_d = '0;
          tx_en_d    = 1'b0;
          tx_d_d     = '0;
          done_d     = 1'b1;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
        end else begin
          byte_cnt_d = byte_cnt_q - LEN_ONE;
          tx_d_d     = bus.ird_data;
        end
      end

      IFG: begin
        tx_en_d = 1'b0;
        tx_d_d  = '0;
        if (cnt_q == IFG_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_en_d = 1'b0;
        tx_d_d  = '0;
      end
    endcase

    // Read strobes run as one contiguous burst. With a one-byte preamble
    // the burst has to start together with the frame itself.
    if (pPREAMBLE_LEN >= 2) begin
      rd_go = (state_q == PREAMBLE) && (cnt_q == PRE_RD);
    end else begin
      rd_go    = start;
      rd_avail = start ? bus.ilen_pac : rd_cnt_q;
    end
    if ((rd_go || ord_en_q) && (rd_avail != '0)) begin
      ord_en_d = 1'b1;
      rd_cnt_d = rd_avail - LEN_ONE;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset drops every output immediately.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      rd_cnt_q   <= '0;
      allow_q    <= 1'b0;
      ord_en_q   <= 1'b0;
      len_pop_q  <= 1'b0;
      tx_d_q     <= '0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      // pause control is registered once, so a start follows a raise of
      // itx_allow by two cycles
      allow_q    <= bus.itx_allow;
      ord_en_q   <= ord_en_d;
      len_pop_q  <= len_pop_d;
      tx_d_q     <= tx_d_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.ord_en    = ord_en_q;
  assign bus.olen_pop  = len_pop_q;
  assign bus.otx_d     = tx_d_q;
  assign bus.otx_en    = tx_en_q;
  assign bus.obusy     = busy_q;
  assign bus.opkt_done = done_q;
  assign bus.olen_err  = len_err_q;
  assign bus.opkt_cnt  = pkt_cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_packet_mem_tx.sv
// Bench for packet_mem_tx: a small packet memory model feeds the block,
// a table of packets is sent and checked byte by byte, and hand-written
// sequences cover back-to-back frames, illegal lengths, pause and reset.
module tb_packet_mem_tx;
  localparam int DW   = 8;
  localparam int MAXL = 1536;
  localparam int LW   = $clog2(MAXL);
  localparam int PRE  = 7;
  localparam int IFG  = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  packet_mem_tx_if #(.pDATA_WIDTH(DW), .pLEN_WIDTH(LW)) bus();

  packet_mem_tx #(
    .pDATA_WIDTH(DW), .pMAX_PACKET_LENGHT(MAXL), .pLEN_WIDTH(LW),
    .pPREAMBLE_LEN(PRE), .pIFG_LEN(IFG)
  ) dut (
    .iclk (clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  // ---------------- packet memory model ----------------
  logic [LW-1:0] len_mem [0:63];
  logic [DW-1:0] byte_mem[0:4095];
  int            len_wr  = 0;
  int            byte_wr = 0;
  int            len_rd;
  int            byte_rd;
  logic [DW-1:0] rd_data_q;
  logic          allow = 1'b0;

  assign bus.iempty    = (len_rd == len_wr);
  assign bus.ilen_pac  = len_mem[len_rd[5:0]];
  assign bus.ird_data  = rd_data_q;
  assign bus.itx_allow = allow;

  // memory is reset together with the transmitter and loses its contents
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      len_rd    <= len_wr;
      byte_rd   <= byte_wr;
      rd_data_q <= '0;
    end else begin
      if (bus.olen_pop) len_rd <= len_rd + 1;
      if (bus.ord_en) begin
        rd_data_q <= byte_mem[byte_rd[11:0]];
        byte_rd   <= byte_rd + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_pkt_cnt = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int len, input logic [7:0] seed);
    for (int k = 0; k < len; k++) begin
      byte_mem[byte_wr[11:0]] = seed + 8'(k);
      byte_wr++;
    end
    len_mem[len_wr[5:0]] = LW'(len);
    len_wr++;
  endtask

  task automatic push_bad(input int len);
    len_mem[len_wr[5:0]] = LW'(len);
    len_wr++;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus.obusy && t < 3000) begin @(negedge clk); t++; end
    check({name, ".idle_reached"}, 32'(bus.obusy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".ord_en"},    32'(bus.ord_en),    32'd0);
    check({name, ".olen_pop"},  32'(bus.olen_pop),  32'd0);
    check({name, ".otx_d"},     32'(bus.otx_d),     32'd0);
    check({name, ".otx_en"},    32'(bus.otx_en),    32'd0);
    check({name, ".obusy"},     32'(bus.obusy),     32'd0);
    check({name, ".opkt_done"}, 32'(bus.opkt_done), 32'd0);
    check({name, ".olen_err"},  32'(bus.olen_err),  32'd0);
    check({name, ".opkt_cnt"},  32'(bus.opkt_cnt),  32'd0);
  endtask

  // Waits for a frame and follows it to its first gap cycle. Returns on
  // the negedge of that cycle (T0 + frame length).
  task automatic check_frame(input string name, input int len, input logic [7:0] seed,
                             input int exp_en, input int exp_rd);
    int t = 0;
    int en_cnt = 0;
    int rd_cnt = 0;
    int rd_first = -1;
    int rd_last = -1;
    int extra_pop = 0;
    int data_bad = 0;
    logic [DW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < len; k++) exp_q.push_back(seed + 8'(k));

    while (!bus.otx_en && t < 300) begin @(negedge clk); t++; end
    if (!bus.otx_en) begin
      check({name, ".start_timeout"}, 32'd1, 32'd0);
      return;
    end
    check({name, ".pop_at_t0"},  32'(bus.olen_pop), 32'd1);
    check({name, ".busy_at_t0"}, 32'(bus.obusy),    32'd1);
    while (bus.otx_en && en_cnt < exp_en + 50) begin
      if (exp_q.size() == 0) data_bad++;
      else begin
        e = exp_q.pop_front();
        if (bus.otx_d !== e) data_bad++;
      end
      if (bus.ord_en) begin
        if (rd_first < 0) rd_first = en_cnt;
        rd_last = en_cnt;
        rd_cnt++;
      end
      if (en_cnt > 0 && bus.olen_pop) extra_pop++;
      en_cnt++;
      @(negedge clk);
    end
    exp_pkt_cnt = exp_pkt_cnt + 16'd1;
    check({name, ".en_cycles"},    32'(en_cnt),    32'(exp_en));
    check({name, ".byte_errors"},  32'(data_bad),  32'd0);
    check({name, ".rd_pulses"},    32'(rd_cnt),    32'(exp_rd));
    check({name, ".rd_first"},     32'(rd_first),  32'(PRE - 1));
    check({name, ".rd_last"},      32'(rd_last),   32'(PRE - 2 + exp_rd));
    check({name, ".extra_pop"},    32'(extra_pop), 32'd0);
    check({name, ".done_pulse"},   32'(bus.opkt_done), 32'd1);
    check({name, ".ifg_txd"},      32'(bus.otx_d), 32'd0);
    check({name, ".ifg_rd"},       32'(bus.ord_en), 32'd0);
    check({name, ".pkt_cnt"},      32'(bus.opkt_cnt), 32'(exp_pkt_cnt));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         len;
    logic [7:0] seed;
    int         exp_en;  // preamble + SFD + payload cycles
    int         exp_rd;  // read strobes
  } vec_t;
  vec_t vecs[5];

  initial begin
    int t;
    int cnt;
    int gap;
    int bad_lens[3];

    vecs[0] = '{len: 64,   seed: 8'h00, exp_en: 72,   exp_rd: 64};
    vecs[1] = '{len: 1,    seed: 8'h3C, exp_en: 9,    exp_rd: 1};
    vecs[2] = '{len: 2,    seed: 8'hFE, exp_en: 10,   exp_rd: 2};
    vecs[3] = '{len: 5,    seed: 8'h90, exp_en: 13,   exp_rd: 5};
    vecs[4] = '{len: 1536, seed: 8'h20, exp_en: 1544, exp_rd: 1536};
    bad_lens[0] = 0;
    bad_lens[1] = 1600;
    bad_lens[2] = 1537;

    // ---- reset at power-up and again mid-idle ----
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset0");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_idle");
    check("reset_idle.state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven single frames ----
    allow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_pkt(vecs[i].len, vecs[i].seed);
      check_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].seed,
                  vecs[i].exp_en, vecs[i].exp_rd);
      wait_idle($sformatf("vec%0d", i));
    end

    // ---- back-to-back: len 64 then len 1 ----
    push_pkt(64, 8'h40);
    push_pkt(1, 8'hA5);
    check_frame("b2b_a", 64, 8'h40, 72, 64);
    gap = 0;
    while (!bus.otx_en && gap < 100) begin gap++; @(negedge clk); end
    check("b2b.gap_cycles", 32'(gap), 32'd13);
    check_frame("b2b_b", 1, 8'hA5, 9, 1);
    wait_idle("b2b");

    // ---- illegal lengths ----
    foreach (bad_lens[i]) begin
      push_bad(bad_lens[i]);
      t = 0;
      while (!bus.olen_pop && t < 20) begin @(negedge clk); t++; end
      check($sformatf("bad%0d.pop", i), 32'(bus.olen_pop), 32'd1);
      check($sformatf("bad%0d.err", i), 32'(bus.olen_err), 32'd1);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (bus.otx_en || bus.ord_en || bus.olen_pop || bus.olen_err) cnt++;
      end
      check($sformatf("bad%0d.quiet", i), 32'(cnt), 32'd0);
      check($sformatf("bad%0d.empty", i), 32'(bus.iempty), 32'd1);
      check($sformatf("bad%0d.pkt_cnt", i), 32'(bus.opkt_cnt), 32'(exp_pkt_cnt));
    end

    // ---- pause control ----
    allow = 1'b0;
    repeat (2) @(negedge clk);
    push_pkt(64, 8'h10);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.otx_en || bus.ord_en || bus.olen_pop || bus.obusy) cnt++;
    end
    check("pause.quiet", 32'(cnt), 32'd0);
    allow = 1'b1;
    @(negedge clk);
    check("pause.en_after_1", 32'(bus.otx_en), 32'd0);
    @(negedge clk);
    check("pause.en_after_2", 32'(bus.otx_en), 32'd1);
    fork
      check_frame("pause", 64, 8'h10, 72, 64);
      begin
        repeat (20) @(negedge clk);
        allow = 1'b0;
      end
    join
    wait_idle("pause");
    allow = 1'b1;

    // ---- asynchronous reset mid-frame ----
    push_pkt(64, 8'h80);
    t = 0;
    while (!bus.otx_en && t < 50) begin @(negedge clk); t++; end
    check("arst.started", 32'(bus.otx_en), 32'd1);
    repeat (30) @(negedge clk);
    check("arst.pre_rd", 32'(bus.ord_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.otx_en", 32'(bus.otx_en), 32'd0);
    check("arst.ord_en", 32'(bus.ord_en), 32'd0);
    check("arst.obusy",  32'(bus.obusy),  32'd0);
    check("arst.otx_d",  32'(bus.otx_d),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pkt_cnt = 16'd0;
    @(negedge clk);
    check("arst.pkt_cnt_cleared", 32'(bus.opkt_cnt), 32'd0);
    push_pkt(64, 8'h33);
    check_frame("arst_next", 64, 8'h33, 72, 64);
    wait_idle("arst_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard stop in case a wait above is never released
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/packet_mem_tx.md
# packet_mem_tx

Transmit-side companion to the packet receive memory. Pulls complete, CRC-checked packets out of the packet memory (length FIFO + byte SRAM) and serialises them onto an 8-bit GMII-style transmit interface. Each frame is sent as preamble, SFD, then payload, followed by an enforced inter-frame gap. The block sits between the packet memory read port and the PHY/MAC transmit pins.

## Interface
Parameters:
- pDATA_WIDTH, 8, byte width of memory data and txd
- pMAX_PACKET_LENGHT, 1536, largest legal packet length in bytes
- pLEN_WIDTH, $clog2(pMAX_PACKET_LENGHT), width of length bus and byte counter
- pPREAMBLE_LEN, 7, number of 0x55 preamble bytes
- pIFG_LEN, 12, inter-frame gap cycles counted in IFG state

Ports (one clock `iclk`; reset `i_rst` asynchronous, active-high):
- iclk  in  1  clock
- i_rst  in  1  async active-high reset
- iempty  in  1  memory holds no complete packet
- ilen_pac  in  pLEN_WIDTH  length of head packet; valid while iempty=0
- ird_data  in  pDATA_WIDTH  memory byte; valid the cycle after ord_en
- itx_allow  in  1  transmission permitted (pause control)
- ord_en  out  1  byte read strobe to memory, one byte per cycle high
- olen_pop  out  1  one-cycle pulse consuming head length entry
- otx_d  out  pDATA_WIDTH  transmit data
- otx_en  out  1  transmit enable
- obusy  out  1  state != IDLE
- opkt_done  out  1  one-cycle pulse at end of frame
- olen_err  out  1  one-cycle pulse when head length is illegal
- opkt_cnt  out  16  transmitted packet count, wraps

## Operation
- All outputs registered. Reset value of every output: 0. Reset puts FSM in IDLE and clears all counters.
- FSM states: IDLE, PREAMBLE, SFD, DATA, IFG.
- IDLE:
  - Start condition: iempty=0 & itx_allow=1 & 1<=ilen_pac<=pMAX_PACKET_LENGHT. On start, latch ilen_pac into the byte counter, pulse olen_pop, go to PREAMBLE.
  - If iempty=0 & itx_allow=1 & the length is illegal (0 or >pMAX_PACKET_LENGHT): pulse olen_pop and olen_err, no frame, no ord_en, stay IDLE for at least one cycle.
- PREAMBLE: otx_en=1, otx_d=0x55 for pPREAMBLE_LEN cycles, then SFD.
- SFD: otx_d=0xD5 for one cycle, then DATA.
- DATA: otx_d=ird_data (registered). Lasts exactly len cycles, then IFG.
- ord_en issues exactly len pulses per frame, contiguous, timed so data lines up with DATA.
- IFG: otx_en=0, otx_d=0 for pIFG_LEN cycles, then IDLE. opkt_done pulses and opkt_cnt increments on the first IFG cycle.
- itx_allow and iempty are sampled only in IDLE. Changes mid-frame have no effect; a stored packet is always complete, so there is no underrun.
- Counter arithmetic: the byte counter counts down in pLEN_WIDTH bits and never underflows. opkt_cnt wraps from 0xFFFF to 0.
- Reset mid-frame: outputs drop to 0 asynchronously and the frame is truncated. The memory must be reset together with this block; no recovery of the partially read packet.

## Timing
- T0 is the first cycle otx_en=1. The IDLE start decision is made at T0-1.
- olen_pop is high at T0 only.
- otx_d sequence:
  - 0x55 at T0..T0+pPREAMBLE_LEN-1; with defaults, T0..T6.
  - 0xD5 at T7.
  - Payload byte k at T8+k, for 0<=k<len.
- ord_en is high at T6..T5+len; pulse j returns byte j at T7+j, driven at T8+j.
- otx_en is high for pPREAMBLE_LEN+1+len cycles and falls at T8+len.
- opkt_done is high at T8+len.
- Back-to-back frames: otx_en stays low for exactly pIFG_LEN+1 cycles (13 with defaults) when the next packet is ready at IDLE entry.
- obusy is high from T0 through the last IFG cycle.

## Test plan
1. Reset check: assert i_rst mid-idle -> all outputs 0, opkt_cnt=0, obusy=0.
2. Single packet, len=64, bytes 0x00..0x3F:
   - otx_d = 7×0x55, 0xD5, then 0x00..0x3F.
   - otx_en high 72 cycles; ord_en high 64 cycles starting T6.
   - olen_pop at T0, opkt_done at T72, opkt_cnt=1.
3. Back-to-back packets, len 64 then len 1 (byte 0xA5): otx_en low exactly 13 cycles between frames; second frame is 9 cycles long, ending in 0xA5; opkt_cnt=2.
4. Illegal lengths ilen_pac=0, then 1600:
   - Each gives one olen_pop with olen_err.
   - otx_en and ord_en never assert; opkt_cnt unchanged.
5. Pause control:
   - itx_allow=0 with iempty=0 -> no activity for 100 cycles.
   - Raise itx_allow -> otx_en rises 2 cycles later.
   - Drop itx_allow at T20 -> frame completes normally.
6. Async reset at T30 of a len=64 frame: otx_en and ord_en go to 0 without a clock edge; after release with a fresh len=64 packet, the frame is normal and opkt_cnt=1.
